// File: rtl/inv_sbox_iter.sv
// Iterative AES inverse S-box: inverse affine, then x^254 in GF(2^8) using one shared squarer and one multiplier.
// Defining INV_SBOX_FWD_MODE_EN adds a 'mode' input that selects the forward S-box instead.
module inv_sbox_iter #(
  parameter int BYPASS_ZERO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
`ifdef INV_SBOX_FWD_MODE_EN
  input  logic       mode,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

  localparam logic [7:0] INV_AFF_C = 8'h05;
  localparam logic [7:0] FWD_AFF_C = 8'h63;
  localparam logic [2:0] LAST_CNT  = 3'd6;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_cnt;
  logic [7:0] r_r;
  logic [7:0] r_x;
  logic [7:0] r_out_data;

  logic [7:0] w_inv_aff;
  logic [7:0] w_x_in;
  logic [7:0] w_sq;
  logic [7:0] w_mul;
  logic [7:0] w_result;
  logic [7:0] w_bypass_data;
  logic       w_bypass;

  // Squaring is linear over GF(2): spread bits to even positions, then reduce by 0x11B.
  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    logic [14:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[2*i] = a[i];
    end
    for (int k = 14; k >= 8; k--) begin
      if (s[k]) begin
        s[k -: 9] = s[k -: 9] ^ 9'h11B;
      end
    end
    return s[7:0];
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ t;
      end
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_inv_aff
    assign w_inv_aff[gi] = in_data[(gi+2)%8] ^ in_data[(gi+5)%8] ^ in_data[(gi+7)%8] ^ INV_AFF_C[gi];
  end

  assign w_sq  = gf_sq(r_r);
  assign w_mul = gf_mul(w_sq, r_x);

`ifdef INV_SBOX_FWD_MODE_EN
  logic       r_mode;
  logic [7:0] w_fwd_aff;

  for (genvar gi = 0; gi < 8; gi++) begin : g_fwd_aff
    assign w_fwd_aff[gi] = w_sq[gi] ^ w_sq[(gi+4)%8] ^ w_sq[(gi+5)%8] ^ w_sq[(gi+6)%8] ^
                           w_sq[(gi+7)%8] ^ FWD_AFF_C[gi];
  end

  assign w_x_in        = mode ? in_data : w_inv_aff;
  assign w_result      = r_mode ? w_fwd_aff : w_sq;
  // Forward affine of a zero inverse is the constant itself.
  assign w_bypass_data = mode ? FWD_AFF_C : 8'h00;
`else
  assign w_x_in        = w_inv_aff;
  assign w_result      = w_sq;
  assign w_bypass_data = 8'h00;
`endif

  assign w_bypass = (BYPASS_ZERO != 0) && (w_x_in == 8'h00);
  assign out_data = r_out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_bypass ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // r walks x^1, x^3, x^7, ... x^127 via r <- r^2 * x, and the last step squares to x^254.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 3'd0;
      r_r        <= 8'h00;
      r_x        <= 8'h00;
      r_out_data <= 8'h00;
`ifdef INV_SBOX_FWD_MODE_EN
      r_mode     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x   <= w_x_in;
            r_r   <= w_x_in;
            r_cnt <= 3'd0;
`ifdef INV_SBOX_FWD_MODE_EN
            r_mode <= mode;
`endif
            if (w_bypass) begin
              r_out_data <= w_bypass_data;
            end
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == LAST_CNT) begin
            r_r        <= w_sq;
            r_out_data <= w_result;
          end else begin
            r_r <= w_mul;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sbox_iter.sv
// Bench for inv_sbox_iter: one instance without and one with the zero bypass, checked against
// S-box tables derived from GF(2^8) inversion by exhaustive search.
module tb_inv_sbox_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid_v  [2];
  logic       in_ready_v  [2];
  logic [7:0] in_data_v   [2];
  logic       out_valid_v [2];
  logic       out_ready_v [2];
  logic [7:0] out_data_v  [2];
  logic       busy_v      [2];
`ifdef INV_SBOX_FWD_MODE_EN
  logic       mode_v      [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  inv_sbox_iter #(.BYPASS_ZERO(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_v[0]),
    .in_ready  (in_ready_v[0]),
    .in_data   (in_data_v[0]),
`ifdef INV_SBOX_FWD_MODE_EN
    .mode      (mode_v[0]),
`endif
    .out_valid (out_valid_v[0]),
    .out_ready (out_ready_v[0]),
    .out_data  (out_data_v[0]),
    .busy      (busy_v[0])
  );

  inv_sbox_iter #(.BYPASS_ZERO(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_v[1]),
    .in_ready  (in_ready_v[1]),
    .in_data   (in_data_v[1]),
`ifdef INV_SBOX_FWD_MODE_EN
    .mode      (mode_v[1]),
`endif
    .out_valid (out_valid_v[1]),
    .out_ready (out_ready_v[1]),
    .out_data  (out_data_v[1]),
    .busy      (busy_v[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int gmul_ref(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ (a << i);
    end
    for (int k = 14; k >= 8; k--) begin
      if (((p >> k) & 1) != 0) p = p ^ ('h11B << (k - 8));
    end
    return p;
  endfunction

  function automatic int rotl8(input int v, input int n);
    return ((v << n) | (v >> (8 - n))) & 'hFF;
  endfunction

  task automatic build_tables();
    int inv;
    int s;
    for (int a = 0; a < 256; a++) begin
      inv = 0;
      for (int b = 1; b < 256; b++) begin
        if (gmul_ref(a, b) == 1) inv = b;
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
      sbox[a]  = 8'(s);
      isbox[s] = 8'(a);
    end
  endtask

  // Latency is counted in rising edges after the accepting edge: 7 when iterating, 0 when the
  // bypass puts out_valid up in the very next cycle.
  task automatic xact(input int sel, input logic [7:0] d, input logic m, input bit rnd_ready,
                      input string tag, output logic [7:0] got);
    logic [7:0] exp_data;
    logic [7:0] held;
    int         exp_lat;
    int         lat;
    int         tries;
    bit         bypass;
    exp_data = m ? sbox[d] : isbox[d];
    bypass   = (sel == 1) && (m ? (d == 8'h00) : (isbox[d] == 8'h00));
    exp_lat  = bypass ? 0 : 7;
    got      = 8'hxx;

    @(negedge clk);
    in_data_v[sel]  = d;
    in_valid_v[sel] = 1'b1;
`ifdef INV_SBOX_FWD_MODE_EN
    mode_v[sel] = m;
`endif
    tries = 0;
    while (!in_ready_v[sel] && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready_v[sel]) begin
      check({tag, " accept timeout"}, 32'(in_ready_v[sel]), 32'd1);
      in_valid_v[sel] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_v[sel] = 1'b0;

    lat = 0;
    while (!out_valid_v[sel] && lat < 40) begin
      check({tag, " in_ready while calc"}, 32'(in_ready_v[sel]), 32'd0);
      check({tag, " busy while calc"}, 32'(busy_v[sel]), 32'd1);
      out_ready_v[sel] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, 32'(out_data_v[sel]), 32'(exp_data));
    check({tag, " in_ready in done"}, 32'(in_ready_v[sel]), 32'd0);
    check({tag, " busy in done"}, 32'(busy_v[sel]), 32'd1);
    got  = out_data_v[sel];
    held = out_data_v[sel];

    tries = 0;
    do begin
      out_ready_v[sel] = (rnd_ready && tries < 30) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      tries++;
      if (!out_ready_v[sel]) begin
        check({tag, " stall valid"}, 32'(out_valid_v[sel]), 32'd1);
        check({tag, " stall data"}, 32'(out_data_v[sel]), 32'(held));
      end
    end while (!out_ready_v[sel]);
    check({tag, " valid drops"}, 32'(out_valid_v[sel]), 32'd0);
    check({tag, " ready again"}, 32'(in_ready_v[sel]), 32'd1);
    out_ready_v[sel] = 1'b0;
    $display("xact %s dut%0d in=%02h mode=%0d out=%02h exp=%02h lat=%0d",
             tag, sel, d, m, held, exp_data, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] d;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid_v[i]  = 1'b0;
      in_data_v[i]   = 8'h00;
      out_ready_v[i] = 1'b0;
`ifdef INV_SBOX_FWD_MODE_EN
      mode_v[i] = 1'b0;
`endif
    end
    build_tables();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset in_ready", 32'(in_ready_v[i]), 32'd1);
      check("reset out_valid", 32'(out_valid_v[i]), 32'd0);
      check("reset out_data", 32'(out_data_v[i]), 32'h00);
      check("reset busy", 32'(busy_v[i]), 32'd0);
    end

    xact(0, 8'h63, 1'b0, 1'b0, "spec63", got);  check("spec 63->00", 32'(got), 32'h00);
    xact(0, 8'h7C, 1'b0, 1'b0, "spec7C", got);  check("spec 7C->01", 32'(got), 32'h01);
    xact(0, 8'hED, 1'b0, 1'b0, "specED", got);  check("spec ED->53", 32'(got), 32'h53);
    xact(0, 8'h00, 1'b0, 1'b0, "spec00", got);  check("spec 00->52", 32'(got), 32'h52);

    for (int i = 0; i < 256; i++) begin
      xact(0, 8'(i), 1'b0, 1'b1, "sweep", got);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    xact(1, 8'h63, 1'b0, 1'b0, "byp63", got);  check("bypass 63->00", 32'(got), 32'h00);
    xact(1, 8'h7C, 1'b0, 1'b0, "byp7C", got);  check("bypass 7C->01", 32'(got), 32'h01);
    for (int i = 0; i < 24; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 8'h63 : 8'($urandom_range(0, 255));
      xact(1, d, 1'b0, 1'b1, "byprnd", got);
    end

    // Reset while cnt==3: accept, then assert rst so it is sampled on the fourth edge after accept.
    @(negedge clk);
    in_data_v[0]  = 8'hED;
    in_valid_v[0] = 1'b1;
    check("midrst accept ready", 32'(in_ready_v[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst busy before", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst in_ready", 32'(in_ready_v[0]), 32'd1);
    check("midrst out_valid", 32'(out_valid_v[0]), 32'd0);
    check("midrst busy", 32'(busy_v[0]), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst stays idle", 32'(out_valid_v[0]), 32'd0);
    xact(0, 8'hED, 1'b0, 1'b0, "postrst", got);  check("postrst ED->53", 32'(got), 32'h53);

`ifdef INV_SBOX_FWD_MODE_EN
    xact(0, 8'h53, 1'b1, 1'b0, "fwd53", got);   check("fwd 53->ED", 32'(got), 32'hED);
    xact(0, 8'h00, 1'b1, 1'b0, "fwd00", got);   check("fwd 00->63", 32'(got), 32'h63);
    xact(0, 8'hED, 1'b0, 1'b0, "invED", got);   check("inv ED->53", 32'(got), 32'h53);
    xact(1, 8'h00, 1'b1, 1'b0, "fwdbyp", got);  check("fwd bypass 00->63", 32'(got), 32'h63);
    for (int i = 0; i < 32; i++) begin
      xact(i % 2, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, "fwdrnd", got);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
